mips_mc_control: RTL and testbench
==================================

// Module: mips_mc_control
// PURPOSE
// Multicycle main control FSM. Decodes the instruction opcode, sequences FETCH/DECODE/EXEC/MEM/WB,
// and drives the datapath enables plus the 3-bit ALUop consumed by alu_control.
// Handshakes with unified instruction/data memory and counts retired instructions.
// PARAMETERS
// TIMEOUT_W  8   width of memory-wait watchdog counter; timeout after 2**TIMEOUT_W-1 wait cycles
// INSTRET_W  32  width of retired-instruction counter
// PORTS
// clk          in   1          clock, rising edge
// rst_n        in   1          synchronous reset, active-low
// opcode       in   6          IR[31:26], valid from DECODE onward
// zero         in   1          ALU zero flag, sampled in EXEC
// mem_ack      in   1          memory done; one-cycle pulse
// mem_req      out  1          memory request, held until ack or timeout
// mem_we       out  1          write strobe (stores), valid with mem_req
// mem_byte     out  1          byte access (lb/sb)
// ir_write     out  1          latch IR
// pc_write     out  1          update PC
// pc_src       out  2          0=ALU result(PC+4), 1=ALUOut(branch target), 2=jump target
// alu_src_a    out  1          0=PC, 1=rs
// alu_src_b    out  2          0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
// ALUop        out  3          `ALUop_* code to alu_control
// reg_write    out  1          register file write enable
// reg_dst      out  1          0=rt, 1=rd
// mem_to_reg   out  1          0=ALUOut, 1=MDR
// illegal      out  1          one-cycle pulse: unknown opcode
// mem_err      out  1          one-cycle pulse: watchdog expired
// instret      out  INSTRET_W  retired-instruction count
// BEHAVIOUR
// - Reset: rst_n low at edge -> state IDLE, watchdog=0, instret=0; every output 0 in IDLE, regardless of phase.
// - States: IDLE(0) FETCH(1) DECODE(2) EXEC(3) MEM(4) WB(5). IDLE->FETCH unconditionally.
// - FETCH: mem_req=1, mem_we=0, alu_src_a=0, alu_src_b=1, ALUop=`ALUop_ADD, pc_src=0.
//   mem_ack=1 -> ir_write=1, pc_write=1 same cycle (Mealy on ack), next DECODE; else stay.
// - DECODE (1 cycle): alu_src_a=0, alu_src_b=3, ALUop=`ALUop_ADD (branch target into ALUOut); next EXEC,
//   except unknown opcode -> illegal=1, next FETCH, no writes, instret unchanged.
// - Opcodes: RTYPE 000000, addi 001000, subi 001001, slti 001010, andi 001100, ori 001101,
//   lw 100011, lb 100000, sw 101011, sb 101000, beq 000100, bne 000101, j 000010.
// - EXEC ALUop: RTYPE->`ALUop_RTYPE; addi/loads/stores->`ALUop_ADD; subi/beq/bne->`ALUop_SUB;
//   slti->`ALUop_LESS; ori->`ALUop_OR; andi->`ALUop_AND (added to mips_defines.vh).
//   alu_src_a=1; alu_src_b=0 for RTYPE/beq/bne, 2 otherwise.
// - EXEC next: RTYPE/imm-ALU->WB; load/store->MEM; beq: pc_write=zero, pc_src=1; bne: pc_write=~zero,
//   pc_src=1; j: pc_write=1, pc_src=2; branch/jump -> FETCH, instret+1.
// - MEM: mem_req=1, mem_we=1 for sw/sb, mem_byte=1 for lb/sb. On ack: store -> FETCH, instret+1;
//   load -> WB.
// - WB (1 cycle): reg_write=1; reg_dst=1 for RTYPE else 0; mem_to_reg=1 for loads; next FETCH, instret+1.
// - Latency with immediate ack: branch/j 3 cycles, RTYPE/imm/store 4, load 5.
// - Watchdog: counts cycles mem_req=1 without ack in FETCH/MEM, clears on state change.
//   At all-ones: mem_err=1, mem_req drops, next FETCH, no writes, instret unchanged.
//   ack on the expiry cycle wins (normal completion, no mem_err).
// - mem_ack outside FETCH/MEM ignored. instret wraps to 0 at all-ones.
// - Reset mid-transfer: mem_req low from next edge; late ack in IDLE ignored.
// TESTING
// - Reset held 3 cycles, release -> all outputs 0 in IDLE, mem_req=1 one cycle later, instret=0.
// - add (op 000000) with ack in first FETCH cycle -> ALUop=`ALUop_RTYPE in EXEC, reg_write=1,
//   reg_dst=1 in cycle 4, instret=1.
// - lw, ack delayed 3 cycles in MEM -> mem_req held 4 cycles, mem_to_reg=1 in WB, 8 cycles total.
// - beq with zero=1 -> pc_write=1, pc_src=1 in EXEC; bne with zero=1 -> pc_write=0; both instret+1.
// - opcode 111111 -> illegal pulse in DECODE, return to FETCH, reg_write/pc_write never set after fetch.
// - TIMEOUT_W=3, no ack -> mem_err after 7 wait cycles, back to FETCH; rst_n low during MEM -> IDLE next edge.

Source files
------------

// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle MIPS main control FSM with a unified
// memory handshake, memory-wait watchdog and retired-instruction counter.
module mips_mc_control #(
  parameter int TIMEOUT_W = 8,
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [5:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_byte,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           ALUop,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 illegal,
  output logic                 mem_err,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [2:0] ALUop_ADD   = 3'd0;
  localparam logic [2:0] ALUop_SUB   = 3'd1;
  localparam logic [2:0] ALUop_AND   = 3'd2;
  localparam logic [2:0] ALUop_OR    = 3'd3;
  localparam logic [2:0] ALUop_LESS  = 3'd4;
  localparam logic [2:0] ALUop_RTYPE = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  state_t               state;
  logic [TIMEOUT_W-1:0] wd;

  logic       is_r;
  logic       is_imm;
  logic       is_load;
  logic       is_store;
  logic       is_byte;
  logic       is_beq;
  logic       is_bne;
  logic       is_j;
  logic       legal;
  logic [2:0] exec_op;

  logic busy;
  logic wd_max;
  logic expire;
  logic retire;

  always_comb begin
    is_r     = 1'b0;
    is_imm   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_j     = 1'b0;
    exec_op  = ALUop_ADD;
    case (opcode)
      OP_RTYPE: begin
        is_r    = 1'b1;
        exec_op = ALUop_RTYPE;
      end
      OP_ADDI: is_imm = 1'b1;
      OP_SUBI: begin
        is_imm  = 1'b1;
        exec_op = ALUop_SUB;
      end
      OP_SLTI: begin
        is_imm  = 1'b1;
        exec_op = ALUop_LESS;
      end
      OP_ANDI: begin
        is_imm  = 1'b1;
        exec_op = ALUop_AND;
      end
      OP_ORI: begin
        is_imm  = 1'b1;
        exec_op = ALUop_OR;
      end
      OP_LW: is_load = 1'b1;
      OP_LB: begin
        is_load = 1'b1;
        is_byte = 1'b1;
      end
      OP_SW: is_store = 1'b1;
      OP_SB: begin
        is_store = 1'b1;
        is_byte  = 1'b1;
      end
      OP_BEQ: begin
        is_beq  = 1'b1;
        exec_op = ALUop_SUB;
      end
      OP_BNE: begin
        is_bne  = 1'b1;
        exec_op = ALUop_SUB;
      end
      OP_J: is_j = 1'b1;
      default: ;
    endcase
    legal = |{is_r, is_imm, is_load, is_store,
              is_beq, is_bne, is_j};
  end

  assign busy   = (state == FETCH) || (state == MEM);
  assign wd_max = &wd;
  // an ack on the expiry cycle still completes the transfer
  assign expire = busy && wd_max && !mem_ack;

  always_comb begin
    retire = 1'b0;
    unique case (state)
      EXEC:    retire = is_beq | is_bne | is_j;
      MEM:     retire = mem_ack & is_store;
      WB:      retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      wd      <= '0;
      instret <= '0;
    end else begin
      if (busy && !mem_ack && !wd_max)
        wd <= wd + 1'b1;
      else
        wd <= '0;
      instret <= instret + INSTRET_W'(retire);
      unique case (state)
        IDLE:   state <= FETCH;
        FETCH:  if (mem_ack) state <= DECODE;
        DECODE: state <= legal ? EXEC : FETCH;
        EXEC: begin
          if (is_r || is_imm)
            state <= WB;
          else if (is_load || is_store)
            state <= MEM;
          else
            state <= FETCH;
        end
        MEM: begin
          if (mem_ack)
            state <= is_store ? FETCH : WB;
          else if (expire)
            state <= FETCH;
        end
        WB:      state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_byte   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    ALUop      = ALUop_ADD;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    mem_err    = expire;
    unique case (state)
      FETCH: begin
        mem_req   = !expire;
        alu_src_b = 2'd1;
        ir_write  = mem_ack;
        pc_write  = mem_ack;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        illegal   = !legal;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = (is_r || is_beq || is_bne) ? 2'd0 : 2'd2;
        ALUop     = exec_op;
        if (is_beq || is_bne) begin
          pc_write = is_beq ? zero : !zero;
          pc_src   = 2'd1;
        end else if (is_j) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
        end
      end
      MEM: begin
        mem_req  = !expire;
        mem_we   = is_store && !expire;
        mem_byte = is_byte && !expire;
      end
      WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_load;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: plan-driven check of the multicycle control FSM
// against per-cycle expectations derived from instruction semantics.
module tb_mips_mc_control;

  localparam logic [2:0] A_ADD   = 3'd0;
  localparam logic [2:0] A_SUB   = 3'd1;
  localparam logic [2:0] A_AND   = 3'd2;
  localparam logic [2:0] A_OR    = 3'd3;
  localparam logic [2:0] A_LESS  = 3'd4;
  localparam logic [2:0] A_RTYPE = 3'd7;

  localparam logic [5:0] O_R    = 6'b000000;
  localparam logic [5:0] O_ADDI = 6'b001000;
  localparam logic [5:0] O_SUBI = 6'b001001;
  localparam logic [5:0] O_SLTI = 6'b001010;
  localparam logic [5:0] O_ANDI = 6'b001100;
  localparam logic [5:0] O_ORI  = 6'b001101;
  localparam logic [5:0] O_LW   = 6'b100011;
  localparam logic [5:0] O_LB   = 6'b100000;
  localparam logic [5:0] O_SW   = 6'b101011;
  localparam logic [5:0] O_SB   = 6'b101000;
  localparam logic [5:0] O_BEQ  = 6'b000100;
  localparam logic [5:0] O_BNE  = 6'b000101;
  localparam logic [5:0] O_J    = 6'b000010;
  localparam logic [5:0] O_BAD  = 6'b111111;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_byte;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] aluop;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic       mem_err;
    logic [2:0] instret;
  } out_t;

  typedef struct packed {
    logic       rst_n;
    logic       ack;
    logic       zero;
    logic [5:0] op;
    out_t       e;
    logic       mask_alu;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ack;
  logic       mem_req, mem_we, mem_byte, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] ALUop;
  logic       reg_write, reg_dst, mem_to_reg, illegal, mem_err;
  logic [2:0] instret;

  mips_mc_control #(
    .TIMEOUT_W(3),
    .INSTRET_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_byte(mem_byte), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ALUop(ALUop), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .mem_err(mem_err),
    .instret(instret)
  );

  always #5 clk = ~clk;

  out_t got;
  assign got = {mem_req, mem_we, mem_byte, ir_write, pc_write, pc_src,
                alu_src_a, alu_src_b, ALUop, reg_write, reg_dst,
                mem_to_reg, illegal, mem_err, instret};

  rec_t       plan[$];
  rec_t       cur;
  bit         active = 0;
  int         idx = 0;
  int         checks = 0;
  int         errors = 0;
  int         m_instret = 0;
  int         n_illegal = 0;
  int         n_err = 0;
  logic [5:0] cur_op = '0;
  logic       cur_zero = 1'b0;

  function automatic bit legal_op(input logic [5:0] op);
    case (op)
      O_R, O_ADDI, O_SUBI, O_SLTI, O_ANDI, O_ORI,
      O_LW, O_LB, O_SW, O_SB, O_BEQ, O_BNE, O_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_for(input logic [5:0] op);
    case (op)
      O_R:                 return A_RTYPE;
      O_SUBI, O_BEQ, O_BNE: return A_SUB;
      O_SLTI:              return A_LESS;
      O_ANDI:              return A_AND;
      O_ORI:               return A_OR;
      default:             return A_ADD;
    endcase
  endfunction

  task automatic cyc(input logic r, input logic a, input out_t e,
                     input logic m);
    rec_t x;
    e.instret  = 3'(m_instret);
    x.rst_n    = r;
    x.ack      = a;
    x.zero     = cur_zero;
    x.op       = cur_op;
    x.e        = e;
    x.mask_alu = m;
    plan.push_back(x);
  endtask

  task automatic bump();
    m_instret = (m_instret + 1) % 8;
  endtask

  task automatic fetch(input int fw);
    out_t e;
    e = '0;
    e.mem_req   = 1'b1;
    e.alu_src_b = 2'd1;
    e.aluop     = A_ADD;
    for (int i = 0; i < fw; i++) cyc(1, 0, e, 0);
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    cyc(1, 1, e, 0);
  endtask

  task automatic fetch_timeout();
    out_t e;
    e = '0;
    e.mem_req   = 1'b1;
    e.alu_src_b = 2'd1;
    for (int i = 0; i < 7; i++) cyc(1, 0, e, 0);
    e.mem_req = 1'b0;
    e.mem_err = 1'b1;
    cyc(1, 0, e, 0);
  endtask

  // one instruction; mw >= 8 means the data access never acks
  task automatic instr(input logic [5:0] op, input int fw, input int mw,
                       input logic z, input logic stray);
    out_t e;
    bit br, ld, st;
    br = (op == O_BEQ) || (op == O_BNE);
    ld = (op == O_LW) || (op == O_LB);
    st = (op == O_SW) || (op == O_SB);
    cur_op   = op;
    cur_zero = z;
    fetch(fw);
    e = '0;
    e.alu_src_b = 2'd3;
    e.illegal   = !legal_op(op);
    cyc(1, stray, e, 0);
    if (!legal_op(op)) return;
    e = '0;
    e.alu_src_a = 1'b1;
    e.alu_src_b = (op == O_R || br) ? 2'd0 : 2'd2;
    e.aluop     = alu_for(op);
    if (op == O_BEQ) begin
      e.pc_write = z;
      e.pc_src   = 2'd1;
    end else if (op == O_BNE) begin
      e.pc_write = !z;
      e.pc_src   = 2'd1;
    end else if (op == O_J) begin
      e.pc_write = 1'b1;
      e.pc_src   = 2'd2;
    end
    cyc(1, stray, e, op == O_J);
    if (br || op == O_J) begin
      bump();
      return;
    end
    if (ld || st) begin
      e = '0;
      e.mem_req  = 1'b1;
      e.mem_we   = st;
      e.mem_byte = (op == O_LB) || (op == O_SB);
      for (int i = 0; i < ((mw >= 8) ? 7 : mw); i++) cyc(1, 0, e, 0);
      if (mw >= 8) begin
        e = '0;
        e.mem_err = 1'b1;
        cyc(1, 0, e, 0);
        return;
      end
      cyc(1, 1, e, 0);
      if (st) begin
        bump();
        return;
      end
    end
    e = '0;
    e.reg_write  = 1'b1;
    e.reg_dst    = (op == O_R);
    e.mem_to_reg = ld;
    cyc(1, stray, e, 0);
    bump();
  endtask

  task automatic reset_in_mem();
    out_t e;
    cur_op   = O_LW;
    cur_zero = 1'b0;
    fetch(0);
    e = '0;
    e.alu_src_b = 2'd3;
    cyc(1, 0, e, 0);
    e = '0;
    e.alu_src_a = 1'b1;
    e.alu_src_b = 2'd2;
    e.aluop     = A_ADD;
    cyc(1, 0, e, 0);
    e = '0;
    e.mem_req = 1'b1;
    cyc(0, 0, e, 0);
    m_instret = 0;
    cyc(1, 1, '0, 0);
  endtask

  task automatic pin(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    out_t msk;
    if (active) begin
      msk = '1;
      if (cur.mask_alu) msk.aluop = '0;
      checks++;
      if (((got ^ cur.e) & msk) !== '0) begin
        errors++;
        $display("FAIL cycle%0d op=%b outputs: got %h expected %h",
                 idx, cur.op, got, cur.e);
      end
      if (illegal === 1'b1) n_illegal++;
      if (mem_err === 1'b1) n_err++;
    end
  end

  initial begin
    int n0;
    int len_add, len_lw, len_beq, len_bad, len_to;
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    zero    = 1'b0;
    opcode  = '0;

    for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0);
    cyc(1, 0, '0, 0);
    n0 = plan.size();
    instr(O_R, 0, 0, 0, 0);
    len_add = plan.size() - n0;
    n0 = plan.size();
    instr(O_LW, 0, 3, 0, 0);
    len_lw = plan.size() - n0;
    n0 = plan.size();
    instr(O_BEQ, 0, 0, 1, 0);
    len_beq = plan.size() - n0;
    instr(O_BNE, 0, 0, 1, 0);
    n0 = plan.size();
    instr(O_BAD, 0, 0, 0, 0);
    len_bad = plan.size() - n0;
    instr(O_ADDI, 2, 0, 0, 1);
    instr(O_SUBI, 0, 0, 0, 0);
    instr(O_SLTI, 1, 0, 0, 0);
    instr(O_ANDI, 0, 0, 0, 1);
    instr(O_ORI, 0, 0, 0, 0);
    instr(O_SW, 0, 0, 0, 0);
    instr(O_SB, 0, 1, 0, 1);
    instr(O_LB, 0, 0, 0, 0);
    instr(O_BEQ, 0, 0, 0, 0);
    instr(O_BNE, 0, 0, 0, 0);
    instr(O_J, 0, 0, 0, 1);
    n0 = plan.size();
    fetch_timeout();
    len_to = plan.size() - n0;
    instr(O_LW, 7, 7, 0, 0);
    instr(O_SW, 0, 8, 0, 0);
    reset_in_mem();
    instr(O_R, 0, 0, 0, 0);

    pin("len_add", len_add, 4);
    pin("len_lw_wait3", len_lw, 8);
    pin("len_beq", len_beq, 3);
    pin("len_illegal", len_bad, 2);
    pin("len_fetch_timeout", len_to, 8);

    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      rst_n   = plan[i].rst_n;
      mem_ack = plan[i].ack;
      zero    = plan[i].zero;
      opcode  = plan[i].op;
      cur     = plan[i];
      idx     = i;
      active  = 1;
    end
    @(posedge clk);
    #1;
    active  = 0;
    mem_ack = 1'b0;
    pin("final_instret", int'(instret), 1);
    pin("illegal_pulses", n_illegal, 1);
    pin("mem_err_pulses", n_err, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
